// File: rtl/dec_emitter.sv
// Sequential binary-to-decimal ASCII converter with a valid/ready byte stream output.
// Optional macro DEC_EMITTER_SIGNED_EN: treat in_data as two's-complement and prefix '-'.
module dec_emitter #(
   parameter bit APPEND_NL = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        out_last,
   output logic        busy
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] CONV = 3'd1;
   localparam logic [2:0] SIGN = 3'd2;
   localparam logic [2:0] EMIT = 3'd3;
   localparam logic [2:0] NL   = 3'd4;

   logic [2:0]  state_r;
   logic [31:0] val_r;
   logic        neg_r;
   logic [3:0]  cnt_r;
   logic [7:0]  stack_r [10];
   logic        in_ready_r;
   logic        out_valid_r;
   logic [7:0]  out_data_r;
   logic        out_last_r;
   logic        busy_r;

   logic [31:0] q_s;
   logic [3:0]  d_s;
   logic [7:0]  digit_s;
   logic        xfer_s;
   logic [31:0] mag_s;
   logic        neg_s;

   // Reciprocal divide: exact floor(x/10) for every 32-bit unsigned x.
   function automatic logic [31:0] div10(input logic [31:0] x);
      logic [63:0] p;
      p = {32'd0, x} * 64'h0000_0000_CCCC_CCCD;
      div10 = 32'(p >> 35);
   endfunction

   function automatic logic [3:0] rem10(input logic [31:0] x, input logic [31:0] q);
      rem10 = 4'(x - ((q << 3) + (q << 1)));
   endfunction

   // A digit byte carries out_last only when it is the final byte of the number.
   function automatic logic last_digit(input logic [3:0] cnt);
      last_digit = (cnt == 4'd1) && (APPEND_NL == 1'b0);
   endfunction

   // One decimal digit of the working value per cycle, plus stream handshake.
   always_comb begin
      q_s     = div10(val_r);
      d_s     = rem10(val_r, q_s);
      digit_s = 8'h30 + {4'h0, d_s};
      xfer_s  = out_valid_r && out_ready;
   end

   // Magnitude and sign of the incoming value.
   always_comb begin
      mag_s = in_data;
      neg_s = 1'b0;
`ifdef DEC_EMITTER_SIGNED_EN
      if (in_data[31]) begin
         mag_s = 32'd0 - in_data;
         neg_s = 1'b1;
      end else begin
         mag_s = in_data;
         neg_s = 1'b0;
      end
`else
      mag_s = in_data;
      neg_s = 1'b0;
`endif
   end

   // Control FSM and registered stream outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         val_r       <= 32'd0;
         neg_r       <= 1'b0;
         cnt_r       <= 4'd0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         out_data_r  <= 8'h00;
         out_last_r  <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  val_r      <= mag_s;
                  neg_r      <= neg_s;
                  cnt_r      <= 4'd0;
                  state_r    <= CONV;
                  in_ready_r <= 1'b0;
                  busy_r     <= 1'b1;
               end
            end
            CONV: begin
               cnt_r <= cnt_r + 4'd1;
               val_r <= q_s;
               if (q_s == 32'd0) begin
                  out_valid_r <= 1'b1;
                  if (neg_r) begin
                     state_r    <= SIGN;
                     out_data_r <= 8'h2D;
                     out_last_r <= 1'b0;
                  end else begin
                     // The digit pushed this cycle is the top of the stack.
                     state_r    <= EMIT;
                     out_data_r <= digit_s;
                     out_last_r <= last_digit(cnt_r + 4'd1);
                  end
               end
            end
            SIGN: begin
               if (xfer_s) begin
                  state_r    <= EMIT;
                  out_data_r <= stack_r[cnt_r - 4'd1];
                  out_last_r <= last_digit(cnt_r);
               end
            end
            EMIT: begin
               if (xfer_s) begin
                  cnt_r <= cnt_r - 4'd1;
                  if (cnt_r == 4'd1) begin
                     if (APPEND_NL) begin
                        state_r    <= NL;
                        out_data_r <= 8'h0A;
                        out_last_r <= 1'b1;
                     end else begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        out_data_r  <= 8'h00;
                        out_last_r  <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                     end
                  end else begin
                     out_data_r <= stack_r[cnt_r - 4'd2];
                     out_last_r <= last_digit(cnt_r - 4'd1);
                  end
               end
            end
            NL: begin
               if (xfer_s) begin
                  state_r     <= IDLE;
                  out_valid_r <= 1'b0;
                  out_data_r  <= 8'h00;
                  out_last_r  <= 1'b0;
                  in_ready_r  <= 1'b1;
                  busy_r      <= 1'b0;
               end
            end
            default: begin
               state_r     <= IDLE;
               cnt_r       <= 4'd0;
               out_valid_r <= 1'b0;
               out_data_r  <= 8'h00;
               out_last_r  <= 1'b0;
               in_ready_r  <= 1'b1;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   // Digit stack, least-significant digit at index 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 10; i++) begin
            stack_r[i] <= 8'h00;
         end
      end else if (state_r == CONV) begin
         stack_r[cnt_r] <= digit_s;
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_last  = out_last_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_dec_emitter.sv
// Self-checking bench for dec_emitter: instance 0 appends newline, instance 1 does not.
module tb_dec_emitter;

   logic        clk;
   logic        rst;
   logic        in_valid  [2];
   logic        in_ready  [2];
   logic [31:0] in_data   [2];
   logic        out_valid [2];
   logic        out_ready [2];
   logic [7:0]  out_data  [2];
   logic        out_last  [2];
   logic        busy      [2];

   int checks;
   int failures;

   logic [7:0] exp_q [$];
   logic [7:0] got_q [$];
   logic       last_q [$];
   int         exp_nd;

   dec_emitter #(.APPEND_NL(1'b1)) dut_nl (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
      .out_last(out_last[0]), .busy(busy[0])
   );

   dec_emitter #(.APPEND_NL(1'b0)) dut_raw (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
      .out_last(out_last[1]), .busy(busy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: decimal text of v using plain division and modulo.
   function automatic void model(input logic [31:0] v, input bit nl);
      logic [31:0] m;
      bit          neg;
      logic [7:0]  d [$];
      exp_q.delete();
      m   = v;
      neg = 1'b0;
`ifdef DEC_EMITTER_SIGNED_EN
      if (v[31]) begin
         neg = 1'b1;
         m   = 32'd0 - v;
      end
`endif
      exp_nd = 0;
      do begin
         d.push_front(8'(32'h30 + (m % 32'd10)));
         m = m / 32'd10;
         exp_nd++;
      end while (m != 32'd0);
      if (neg) exp_q.push_back(8'h2D);
      foreach (d[i]) exp_q.push_back(d[i]);
      if (nl) exp_q.push_back(8'h0A);
   endfunction

   // Send v to instance sel and collect its stream; stop_at>0 leaves it mid-stream.
   task automatic run_num(input int sel, input logic [31:0] v, input bit rnd,
                          input int inj_at, input logic [31:0] inj_val, input int stop_at);
      int   guard;
      int   lat;
      int   first;
      bit   done;
      bit   prev_stall;
      bit   ir_high;
      bit   ordy;
      bit   bad_last;
      logic [7:0] pod;
      logic       pol;
      model(v, sel == 0);
      got_q.delete();
      last_q.delete();
      guard = 0;
      @(negedge clk);
      while (!in_ready[sel] && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (in_ready[sel] !== 1'b1) begin
         failures++;
         $display("FAIL idle_wait v=%0d: in_ready=%b required 1", v, in_ready[sel]);
      end
      in_valid[sel]  = 1'b1;
      in_data[sel]   = v;
      out_ready[sel] = 1'b0;
      @(posedge clk);
      lat = 0; first = -1; done = 1'b0; prev_stall = 1'b0; ir_high = 1'b0;
      pod = 8'h00; pol = 1'b0;
      for (int cyc = 0; cyc < 300 && !done && !(stop_at > 0 && got_q.size() >= stop_at); cyc++) begin
         @(negedge clk);
         lat++;
         in_valid[sel] = (cyc + 1 == inj_at);
         in_data[sel]  = (cyc + 1 == inj_at) ? inj_val : v;
         if (prev_stall) begin
            checks++;
            if (out_valid[sel] !== 1'b1 || out_data[sel] !== pod || out_last[sel] !== pol) begin
               failures++;
               $display("FAIL stall_hold v=%0d: valid=%b data=%h last=%b required 1 %h %b",
                        v, out_valid[sel], out_data[sel], out_last[sel], pod, pol);
            end
         end
         if (out_valid[sel] === 1'b1 && first < 0) first = lat;
         if (in_ready[sel] !== 1'b0) ir_high = 1'b1;
         ordy = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
         out_ready[sel] = ordy;
         if (out_valid[sel] === 1'b1 && ordy) begin
            got_q.push_back(out_data[sel]);
            last_q.push_back(out_last[sel]);
            if (out_last[sel] === 1'b1) done = 1'b1;
         end
         prev_stall = (out_valid[sel] === 1'b1) && !ordy;
         pod = out_data[sel];
         pol = out_last[sel];
      end
      in_valid[sel] = 1'b0;
      checks++;
      if (ir_high) begin
         failures++;
         $display("FAIL in_ready_busy v=%0d: in_ready=1 seen required 0 while converting", v);
      end
      checks++;
      if (first != exp_nd + 1) begin
         failures++;
         $display("FAIL latency v=%0d: first out_valid %0d cycles required %0d", v, first, exp_nd + 1);
      end
      if (stop_at == 0) begin
         @(negedge clk);
         out_ready[sel] = 1'b0;
         checks++;
         if (!done || in_ready[sel] !== 1'b1 || out_valid[sel] !== 1'b0) begin
            failures++;
            $display("FAIL finish v=%0d: done=%b in_ready=%b out_valid=%b required 1 1 0",
                     v, done, in_ready[sel], out_valid[sel]);
         end
         checks++;
         if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL length v=%0d: got %0d bytes required %0d", v, got_q.size(), exp_q.size());
         end else begin
            bad_last = 1'b0;
            foreach (exp_q[i]) begin
               checks++;
               if (got_q[i] !== exp_q[i]) begin
                  failures++;
                  $display("FAIL byte v=%0d idx=%0d: got %h required %h", v, i, got_q[i], exp_q[i]);
               end
               if (last_q[i] !== (i == exp_q.size() - 1)) bad_last = 1'b1;
            end
            checks++;
            if (bad_last) begin
               failures++;
               $display("FAIL out_last v=%0d: last flag not only on final byte", v);
            end
         end
      end
   endtask

   task automatic check_idle_outputs(input string name);
      for (int s = 0; s < 2; s++) begin
         checks++;
         if (in_ready[s] !== 1'b1 || out_valid[s] !== 1'b0 || out_data[s] !== 8'h00 ||
             out_last[s] !== 1'b0 || busy[s] !== 1'b0) begin
            failures++;
            $display("FAIL %s inst=%0d: rdy=%b vld=%b data=%h last=%b busy=%b required 1 0 00 0 0",
                     name, s, in_ready[s], out_valid[s], out_data[s], out_last[s], busy[s]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int s = 0; s < 2; s++) begin
         in_valid[s] = 1'b0; in_data[s] = 32'd0; out_ready[s] = 1'b0;
      end
      repeat (3) @(negedge clk);
      check_idle_outputs("reset_state");
      rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("after_reset");
   endtask

   task automatic test_directed();
      run_num(0, 32'd0, 1'b0, 0, 32'd0, 0);
      run_num(1, 32'hFFFF_FFFF, 1'b0, 0, 32'd0, 0);
      run_num(0, 32'h8000_0000, 1'b0, 0, 32'd0, 0);
      run_num(0, 32'hFFFF_FFF6, 1'b0, 0, 32'd0, 0);
      run_num(1, 32'd9, 1'b0, 0, 32'd0, 0);
      run_num(1, 32'd10, 1'b0, 0, 32'd0, 0);
      run_num(0, 32'd1000000000, 1'b0, 0, 32'd0, 0);
      run_num(1, 32'd999999999, 1'b0, 0, 32'd0, 0);
   endtask

   task automatic test_stall();
      run_num(0, 32'd12345, 1'b1, 0, 32'd0, 0);
      run_num(1, 32'd12345, 1'b1, 0, 32'd0, 0);
   endtask

   task automatic test_drop();
      run_num(0, 32'd42, 1'b0, 2, 32'd999, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checks++;
         if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            failures++;
            $display("FAIL drop_idle: out_valid=%b in_ready=%b required 0 1", out_valid[0], in_ready[0]);
         end
      end
      run_num(0, 32'd999, 1'b0, 0, 32'd0, 0);
   endtask

   task automatic test_reset_mid();
      run_num(0, 32'd65535, 1'b0, 0, 32'd0, 2);
      @(posedge clk);
      #1 rst = 1'b1;
      #1 check_idle_outputs("mid_reset");
      @(negedge clk);
      rst = 1'b0;
      out_ready[0] = 1'b0;
      run_num(0, 32'd7, 1'b0, 0, 32'd0, 0);
   endtask

   task automatic test_random();
      logic [31:0] v;
      int          kind;
      for (int it = 0; it < 16; it++) begin
         kind = $urandom_range(0, 2);
         v = (kind == 0) ? 32'($urandom_range(0, 99)) :
             (kind == 1) ? 32'($urandom_range(0, 99999)) : 32'($urandom());
         run_num($urandom_range(0, 1), v, 1'b1, 0, 32'd0, 0);
      end
   endtask

   task automatic test_back_to_back();
      run_num(0, 32'd1, 1'b0, 0, 32'd0, 0);
      run_num(0, 32'd2147483647, 1'b0, 0, 32'd0, 0);
      run_num(1, 32'd4000000000, 1'b0, 0, 32'd0, 0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_directed();
      test_stall();
      test_drop();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
